// File: rtl/spmv_axi_pkg.sv
// Shared AXI encodings and FSM state types for the SpMV Val-channel responder.
package spmv_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_32B    = 3'd5;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/spmv_axi_skid_buf.sv
// Two-entry valid/ready buffer; holds RAM read beats so the read pipeline can
// run at one beat per cycle while the master applies backpressure.
module spmv_axi_skid_buf #(
    parameter int WIDTH = 259
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] ent0;
    logic [WIDTH-1:0] ent1;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;

    assign push      = in_valid && (cnt != 2'd2);
    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt != 2'd0);
    assign level     = cnt;
    // Data reads as zero whenever nothing is presented, so the port idles at 0.
    assign out_data  = out_valid ? (rd_ptr ? ent1 : ent0) : '0;

    // Occupancy and pointer control; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            if (wr_ptr) ent1 <= in_data;
            else        ent0 <= in_data;
        end
    end

endmodule

// File: rtl/spmv_hbm_val_responder.sv
// AXI4 slave serving 256-bit INCR bursts from a word-addressed Val RAM, with a
// write path for host preload. Read and write channels run independently.
module spmv_hbm_val_responder
    import spmv_axi_pkg::*;
#(
    parameter int                ADDR_W      = 48,
    parameter int                DATA_W      = 256,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [1:0]          s_axi_arburst,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [1:0]          s_axi_awburst,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int STRB_W = DATA_W / 8;
    localparam int BEAT_W = DATA_W + 3;

    // Whole burst must be INCR, 32-byte beats, and land entirely inside the RAM.
    function automatic logic burst_legal(input logic [ADDR_W-1:0] addr, input logic [1:0] burst,
                                         input logic [2:0] size, input logic [7:0] len);
        logic [ADDR_W-1:0] off;
        logic [ADDR_W:0]   last_word;
        off       = addr - BASE_ADDR;
        last_word = {1'b0, (off >> 5)} + {{(ADDR_W-7){1'b0}}, len};
        return (burst == AXI_BURST_INCR) && (size == AXI_SIZE_32B) &&
               (addr >= BASE_ADDR) && (last_word < (ADDR_W+1)'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 5);
    endfunction

    logic [DATA_W-1:0] ram [DEPTH_WORDS];

    rd_state_t        rd_state, rd_state_nxt;
    logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
    logic [8:0]       rd_left, rd_left_nxt;
    logic             rd_err, rd_err_nxt;
    logic             vld_p0;
    logic [1:0]       skid_level;
    logic [2:0]       rd_occ;
    logic             rd_deq;
    logic             rd_space;

    wr_state_t        wr_state, wr_state_nxt;
    logic [IDX_W-1:0] wr_idx, wr_idx_nxt;
    logic [8:0]       wr_left, wr_left_nxt;
    logic             wr_err, wr_err_nxt;
    logic             beat_err;
    logic             ram_we;

    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic [1:0]        rresp_p1;
    logic              rlast_p1;
    logic [BEAT_W-1:0] skid_out;

    // Credit check: buffered beats plus the one in the RAM stage must fit in two entries.
    assign rd_deq   = s_axi_rvalid && s_axi_rready;
    assign rd_occ   = {1'b0, skid_level} + {2'b00, vld_p1};
    assign rd_space = (rd_occ < 3'd2) || (rd_deq && (rd_occ == 3'd2));

    // Read FSM state and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
            rd_left  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            rd_idx   <= rd_idx_nxt;
            rd_left  <= rd_left_nxt;
            rd_err   <= rd_err_nxt;
        end
    end

    // Read FSM next state, AR ready, and per-cycle RAM read issue.
    always_comb begin
        rd_state_nxt  = rd_state;
        rd_idx_nxt    = rd_idx;
        rd_left_nxt   = rd_left;
        rd_err_nxt    = rd_err;
        s_axi_arready = 1'b0;
        vld_p0        = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = rstn;
                if (s_axi_arvalid) begin
                    rd_idx_nxt   = word_idx(s_axi_araddr);
                    rd_left_nxt  = {1'b0, s_axi_arlen} + 9'd1;
                    rd_err_nxt   = !burst_legal(s_axi_araddr, s_axi_arburst, s_axi_arsize, s_axi_arlen);
                    rd_state_nxt = R_BURST;
                end
            end
            R_BURST: begin
                if (rd_space) begin
                    vld_p0      = 1'b1;
                    rd_idx_nxt  = rd_idx + 1'b1;
                    rd_left_nxt = rd_left - 9'd1;
                    if (rd_left == 9'd1) rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // ---- stage p0 -> p1: RAM read (read-first), error beats bypass the RAM ----
    // Valid for the RAM output stage.
    always_ff @(posedge clk) begin
        if (!rstn) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
    end

    // RAM read port and beat attributes.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            if (rd_err) rdata_p1 <= '0;
            else        rdata_p1 <= ram[rd_idx];
            rresp_p1 <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            rlast_p1 <= (rd_left == 9'd1);
        end
    end

    // ---- stage p1 -> R channel: skid buffer ----
    spmv_axi_skid_buf #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (vld_p1),
        .in_data   ({rdata_p1, rresp_p1, rlast_p1}),
        .out_valid (s_axi_rvalid),
        .out_ready (s_axi_rready),
        .out_data  (skid_out),
        .level     (skid_level)
    );

    assign {s_axi_rdata, s_axi_rresp, s_axi_rlast} = skid_out;

    // Write FSM state and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_state <= W_IDLE;
            wr_idx   <= '0;
            wr_left  <= '0;
            wr_err   <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_idx   <= wr_idx_nxt;
            wr_left  <= wr_left_nxt;
            wr_err   <= wr_err_nxt;
        end
    end

    // Write FSM next state, handshakes, wlast checking and RAM write enable.
    always_comb begin
        wr_state_nxt  = wr_state;
        wr_idx_nxt    = wr_idx;
        wr_left_nxt   = wr_left;
        wr_err_nxt    = wr_err;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = AXI_RESP_OKAY;
        beat_err      = 1'b0;
        ram_we        = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_axi_awready = rstn;
                if (s_axi_awvalid) begin
                    wr_idx_nxt   = word_idx(s_axi_awaddr);
                    wr_left_nxt  = {1'b0, s_axi_awlen} + 9'd1;
                    wr_err_nxt   = !burst_legal(s_axi_awaddr, s_axi_awburst, s_axi_awsize, s_axi_awlen);
                    wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    // A wlast that disagrees with the beat count poisons this beat and the rest.
                    beat_err   = (s_axi_wlast != (wr_left == 9'd1));
                    ram_we     = rstn && !wr_err && !beat_err;
                    wr_err_nxt = wr_err || beat_err;
                    wr_idx_nxt = wr_idx + 1'b1;
                    if (wr_left != 9'd0) wr_left_nxt = wr_left - 9'd1;
                    if (s_axi_wlast) wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                if (s_axi_bready) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // RAM write port with byte enables.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) ram[wr_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_spmv_hbm_val_responder.sv
// Scoreboard bench for spmv_hbm_val_responder: stimulus pushes expected R beats
// and B responses from a word-array model; monitors pop and compare.
module tb_spmv_hbm_val_responder;

    localparam int          DEPTH = 64;
    localparam logic [47:0] BASE  = 48'h0000_0010_0000;

    typedef struct packed {
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [47:0]  s_axi_araddr;
    logic [1:0]   s_axi_arburst;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [255:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic [47:0]  s_axi_awaddr;
    logic [1:0]   s_axi_awburst;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [255:0] s_axi_wdata;
    logic [31:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;

    int checks = 0;
    int errors = 0;
    int rbeats = 0;
    int rmode  = 0;
    int phase  = 0;

    beat_t        rq[$];
    logic [1:0]   bq[$];
    logic [255:0] mem_m [DEPTH];
    logic [255:0] wbuf [32];
    logic [31:0]  sbuf [32];

    always #5 clk = ~clk;

    spmv_hbm_val_responder #(
        .ADDR_W(48), .DATA_W(256), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
    );

    task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=completion", name);
    endtask

    // Reference rules: INCR, 32-byte beats, every beat inside [BASE, BASE + DEPTH words).
    function automatic bit legal(input longint unsigned addr, input int burst, input int size, input int len);
        if (burst != 1 || size != 5 || addr < longint'(BASE)) return 1'b0;
        return (((addr - longint'(BASE)) >> 5) + longint'(len)) < longint'(DEPTH);
    endfunction

    function automatic int widx(input longint unsigned addr);
        return int'((addr - longint'(BASE)) >> 5);
    endfunction

    // rready pattern generator: 0 = always ready, 1 = repeating 1,0,0,1.
    always @(posedge clk) begin
        #1;
        phase++;
        if (rmode == 1) s_axi_rready = ((phase % 4) == 0) || ((phase % 4) == 3);
        else            s_axi_rready = 1'b1;
    end

    // R and B monitors: compare handshaked beats and check stability while stalled.
    beat_t held;
    bit    hold_v = 0;
    always @(negedge clk) begin
        beat_t exp;
        if (!rstn) begin
            hold_v = 0;
        end else begin
            if (hold_v) check("r_stable", {s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, {1'b1, held});
            if (s_axi_rvalid && s_axi_rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected actual=beat_%0h required=no_beat", s_axi_rdata);
                end else begin
                    exp = rq.pop_front();
                    check("r_beat", {s_axi_rdata, s_axi_rresp, s_axi_rlast}, exp);
                end
                rbeats++;
                hold_v = 0;
            end else if (s_axi_rvalid) begin
                hold_v = 1;
                held   = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
            end else begin
                hold_v = 0;
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected actual=%0d required=no_response", s_axi_bresp);
                end else begin
                    check("b_resp", s_axi_bresp, bq.pop_front());
                end
            end
        end
    end

    task automatic ar_hs(input longint unsigned addr, input int len, input int burst, input int size);
        int n;
        s_axi_araddr  = addr[47:0];
        s_axi_arlen   = 8'(len);
        s_axi_arburst = 2'(burst);
        s_axi_arsize  = 3'(size);
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 200);
        if (!s_axi_arready) note_timeout("ar_handshake");
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic aw_hs(input longint unsigned addr, input int len, input int burst, input int size);
        int n;
        s_axi_awaddr  = addr[47:0];
        s_axi_awlen   = 8'(len);
        s_axi_awburst = 2'(burst);
        s_axi_awsize  = 3'(size);
        s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 200);
        if (!s_axi_awready) note_timeout("aw_handshake");
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_beats(input int nbeats);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            s_axi_wdata  = wbuf[i];
            s_axi_wstrb  = sbuf[i];
            s_axi_wlast  = (i == nbeats - 1);
            s_axi_wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!s_axi_wready && n < 200);
            if (!s_axi_wready) note_timeout("w_handshake");
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
    endtask

    task automatic model_read(input longint unsigned addr, input int len, input int burst, input int size);
        beat_t b;
        bit    ok = legal(addr, burst, size, len);
        int    w  = ok ? widx(addr) : 0;
        for (int i = 0; i <= len; i++) begin
            b.data = ok ? mem_m[w + i] : 256'd0;
            b.resp = ok ? 2'b00 : 2'b10;
            b.last = (i == len);
            rq.push_back(b);
        end
    endtask

    // Model write: beats land in order; a wlast disagreeing with len+1 poisons that beat onwards.
    task automatic model_write(input longint unsigned addr, input int len, input int burst, input int size,
                               input int nbeats);
        bit err = !legal(addr, burst, size, len);
        int w   = err ? 0 : widx(addr);
        for (int i = 0; i < nbeats; i++) begin
            if ((i == nbeats - 1) != (i == len)) err = 1;
            if (!err) begin
                for (int b = 0; b < 32; b++) begin
                    if (sbuf[i][b]) mem_m[w + i][b*8 +: 8] = wbuf[i][b*8 +: 8];
                end
            end
        end
        bq.push_back(err ? 2'b10 : 2'b00);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) note_timeout("drain");
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic do_write(input longint unsigned addr, input int len, input int burst, input int size,
                            input int nbeats);
        model_write(addr, len, burst, size, nbeats);
        aw_hs(addr, len, burst, size);
        w_beats(nbeats);
        wait_idle();
    endtask

    task automatic do_read(input longint unsigned addr, input int len, input int burst, input int size);
        model_read(addr, len, burst, size);
        ar_hs(addr, len, burst, size);
        wait_idle();
    endtask

    function automatic longint unsigned waddr(input int w);
        return longint'(BASE) + longint'(w) * 32;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n, run, best;
        longint unsigned a;
        logic [255:0] oldv, newv;
        rstn = 1'b0;
        s_axi_araddr = '0; s_axi_arburst = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arvalid = 1'b0;
        s_axi_awaddr = '0; s_axi_awburst = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;

        repeat (3) begin @(posedge clk); #1; end
        check("rst_arready", s_axi_arready, 0);
        check("rst_awready", s_axi_awready, 0);
        check("rst_wready", s_axi_wready, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rdata", {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_bresp}, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_arready", s_axi_arready, 1);
        check("post_rst_awready", s_axi_awready, 1);

        // Preload the whole RAM with random words.
        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int i = 0; i < 16; i++) begin
                wbuf[i] = {8{$urandom}};
                sbuf[i] = 32'hFFFF_FFFF;
            end
            do_write(waddr(k * 16), 15, 1, 5, 16);
        end

        // Write 0xA0..0xA3 at BASE+0x40, read back and check first-beat latency.
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 256'hA0 + 256'(i);
            sbuf[i] = 32'hFFFF_FFFF;
        end
        do_write(longint'(BASE) + 64, 3, 1, 5, 4);
        model_read(longint'(BASE) + 64, 3, 1, 5);
        ar_hs(longint'(BASE) + 64, 3, 1, 5);
        @(posedge clk); #1;
        check("r_latency_cyc1", s_axi_rvalid, 0);
        @(posedge clk); #1;
        check("r_latency_cyc2", s_axi_rvalid, 1);
        wait_idle();

        // Full-rate burst: 16 consecutive rvalid cycles.
        model_read(waddr(16), 15, 1, 5);
        ar_hs(waddr(16), 15, 1, 5);
        run = 0; best = 0; n = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            if (s_axi_rvalid) begin
                run++; n++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        check("r_tput_run", best, 16);
        check("r_tput_total", n, 16);
        wait_idle();

        // Backpressure with rready 1,0,0,1.
        rmode = 1;
        start = rbeats;
        do_read(waddr(32), 15, 1, 5);
        rmode = 0;
        check("bp_beat_count", rbeats - start, 16);

        // Out of range, bad burst type, bad write size.
        do_read(waddr(DEPTH - 2), 3, 1, 5);
        do_read(waddr(4), 0, 0, 5);
        do_read(longint'(BASE) - 64, 0, 1, 5);
        for (int i = 0; i < 2; i++) begin
            wbuf[i] = {8{$urandom}};
            sbuf[i] = 32'hFFFF_FFFF;
        end
        do_write(waddr(8), 1, 1, 4, 2);
        do_read(waddr(8), 1, 1, 5);

        // Byte strobes.
        wbuf[0] = '1; sbuf[0] = 32'hFFFF_FFFF;
        do_write(waddr(10), 0, 1, 5, 1);
        wbuf[0] = {8{$urandom}}; sbuf[0] = 32'h0000_000F;
        do_write(waddr(10), 0, 1, 5, 1);
        do_read(waddr(10), 0, 1, 5);

        // Early wlast: len=3 burst ends after 2 beats; first beat must stick.
        for (int i = 0; i < 2; i++) begin
            wbuf[i] = {8{$urandom}};
            sbuf[i] = 32'hFFFF_FFFF;
        end
        do_write(waddr(20), 3, 1, 5, 2);
        do_read(waddr(20), 0, 1, 5);

        // Reset on beat 5 of a len=7 read.
        start = rbeats;
        model_read(waddr(30), 7, 1, 5);
        ar_hs(waddr(30), 7, 1, 5);
        n = 0;
        while (rbeats < start + 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) note_timeout("rst_mid_wait");
        rstn = 1'b0;
        rq.delete();
        @(posedge clk); #1;
        check("rst_mid_rvalid", s_axi_rvalid, 0);
        @(posedge clk); #1;
        check("rst_mid_rvalid2", s_axi_rvalid, 0);
        check("rst_mid_arready", s_axi_arready, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_rel_arready", s_axi_arready, 1);
        repeat (6) begin @(posedge clk); #1; end
        check("rst_no_beats", rbeats - start, 4);
        do_read(waddr(30), 7, 1, 5);

        // Read/write collision on word 5: read sees old data, later read sees new.
        oldv = mem_m[5];
        newv = {8{$urandom}};
        aw_hs(waddr(5), 0, 1, 5);
        model_read(waddr(5), 0, 1, 5);
        ar_hs(waddr(5), 0, 1, 5);
        s_axi_wdata = newv; s_axi_wstrb = 32'hFFFF_FFFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("coll_wready", s_axi_wready, 1);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        bq.push_back(2'b00);
        mem_m[5] = newv;
        wait_idle();
        check("coll_model_changed", (oldv != newv), 1);
        do_read(waddr(5), 0, 1, 5);

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            int len, w, burst, size;
            len   = $urandom_range(0, 7);
            w     = $urandom_range(0, DEPTH + 3);
            burst = ($urandom_range(0, 9) == 0) ? 2 : 1;
            size  = ($urandom_range(0, 9) == 0) ? 4 : 5;
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = {8{$urandom}};
                sbuf[i] = $urandom;
            end
            a = waddr(w) + longint'($urandom_range(0, 31));
            do_write(a, len, burst, size, len + 1);
            len   = $urandom_range(0, 15);
            w     = $urandom_range(0, DEPTH + 3);
            burst = ($urandom_range(0, 9) == 0) ? 0 : 1;
            size  = ($urandom_range(0, 9) == 0) ? 3 : 5;
            a = ($urandom_range(0, 11) == 0) ? longint'(BASE) - 32 : waddr(w) + longint'($urandom_range(0, 31));
            rmode = $urandom_range(0, 1);
            do_read(a, len, burst, size);
            rmode = 0;
        end

        wait_idle();
        check("rq_empty", rq.size(), 0);
        check("bq_empty", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spmv_hbm_val_responder.md
Name: spmv_hbm_val_responder

Overview:
AXI4 memory-mapped responder, the slave end of the Val channel that the SpMV kernels reach through the Val crossbar. It serves 256-bit INCR read bursts from an internal word-addressed RAM, and accepts write bursts so the host path can preload Val data. It stands in for an HBM pseudo-channel in simulation and serves as an on-chip Val store in small builds. No AXI ID ports, because the crossbar ties IDs to 0.

Parameters:
ADDR_W, 48, AXI address width
DATA_W, 256, beat width (fixed; only 256 is supported)
DEPTH_WORDS, 1024, RAM depth in 256-bit words; must be a power of two
BASE_ADDR, 48'h0, byte address of RAM word 0; must be 32-byte aligned

Ports:
clk  in  1  single clock
rstn  in  1  synchronous active-low reset
s_axi_araddr  in  ADDR_W  read address
s_axi_arburst  in  2  read burst type
s_axi_arlen  in  8  read beats minus 1
s_axi_arsize  in  3  read beat size
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_W  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_awaddr  in  ADDR_W  write address
s_axi_awburst  in  2  write burst type
s_axi_awlen  in  8  write beats minus 1
s_axi_awsize  in  3  write beat size
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready

Behaviour:
- Reset (synchronous, rstn=0): all outputs reset to 0, both FSMs go to IDLE, the skid buffer is emptied, and any in-flight burst is discarded with no further beats or responses. RAM contents are not reset. arready and awready assert in the first cycle after rstn=1.
- Address decode: word index = (addr - BASE_ADDR) >> 5. Address bits [4:0] are ignored, so the address is aligned down. The 4 KB boundary is not checked.
- A burst is legal only if burst==2'b01 (INCR), size==3'd5, and every beat word index lies in [0, DEPTH_WORDS-1]. An address below BASE_ADDR is out of range.
- Read FSM states:
  - R_IDLE: arready=1. On an AR handshake, latch the index, the beat count (len+1) and the error flag, then go to R_BURST.
  - R_BURST: arready=0. Issue one RAM read per cycle while the skid buffer has space. RAM latency is 1 cycle.
  - Return to R_IDLE after the last beat has been issued to the buffer. A new AR can then be accepted while earlier beats are still draining.
- Read data path:
  - The first rvalid appears 2 cycles after the AR handshake.
  - Sustained throughput is 1 beat/cycle while rready=1.
  - rdata, rresp and rlast are held stable while rvalid=1 and rready=0, and no beat is dropped or duplicated.
  - A burst is either fully legal or fully illegal. An illegal burst returns len+1 beats with rresp=2'b10 (SLVERR) and rdata=0, and does not read the RAM. A legal burst returns rresp=2'b00.
  - rlast=1 only on beat len+1.
- Write FSM states:
  - W_IDLE: awready=1. On an AW handshake, latch the index, the beat count and the error flag, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the RAM bytes where wstrb=1 (unless the error flag is set), then increments the index. Go to W_RESP on the handshake with wlast=1.
  - If wlast arrives before beat len+1, or is missing on beat len+1, set the error flag. Writes continue to be suppressed after that point, and the burst still terminates on wlast.
  - W_RESP: bvalid=1, with bresp = error ? 2'b10 : 2'b00. Hold until bready, then go to W_IDLE.
- Read/write collision on the same word in the same cycle: the read returns the old data (read-first RAM).
- Read and write channels are fully independent, with no ordering between them.

Decomposition:
- Package spmv_axi_pkg holds:
  - AXI_BURST_INCR=2'b01
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10
  - AXI_SIZE_32B=3'd5
  - the rd_state_t and wr_state_t enums
- Sub-module spmv_axi_skid_buf: a 2-entry valid/ready buffer carrying {rdata, rresp, rlast}. It absorbs the 1-cycle RAM latency so throughput stays at 1 beat/cycle under backpressure.
- The RAM is an inferred simple dual-port array with byte-write enables.

Test Plan:
- Write burst then read back: AW addr=BASE+0x40, len=3, strb all 1, data 0xA0..0xA3. Expect bresp=00. Then AR to the same address, len=3. Expect 4 beats 0xA0..0xA3, rresp=00, rlast only on beat 4, first rvalid 2 cycles after the AR handshake.
- Backpressure: AR len=15 with rready toggling 1,0,0,1 repeatedly. Expect exactly 16 beats, in order, stable while stalled, with no loss or duplication. With rready held at 1, expect 16 consecutive cycles of rvalid.
- Out of range and bad burst: AR index DEPTH_WORDS-2 with len=3 expects 4 beats of SLVERR with rdata=0. AR with arburst=2'b00 expects SLVERR. AW with size=3'd4 expects bresp=10 and RAM unchanged.
- Byte strobes and early wlast: write wstrb=32'h0000_000F over 0xFF.. expects only bytes 0-3 changed. A len=3 write with wlast on beat 2 expects bresp=10, the burst terminating at beat 2, and beat 1 (written before the error) retained.
- Reset mid-operation: assert rstn=0 on beat 5 of a len=7 read. Expect rvalid=0 the next cycle, no further beats, arready=1 the cycle after rstn returns to 1, and RAM data still intact on re-read.
- Collision: read and write hit the same word in the same cycle. Expect the read to return the old value and a subsequent read to return the new value.
